// File: rtl/uart_apb_pkg.sv
// rtl/uart_apb_pkg.sv - shared constants and state encodings for the UART-to-APB bridge
package uart_apb_pkg;

  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_ACK = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h3F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP,
    ST_ABORT
  } cmd_state_e;

  typedef enum logic [1:0] {
    U_IDLE,
    U_START,
    U_DATA,
    U_STOP
  } uart_state_e;

endpackage

// File: rtl/uart_8n1.sv
// rtl/uart_8n1.sv - 8N1 UART receiver (with input synchronizer) and transmitter
module uart_8n1
  import uart_apb_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       uart_rx,
  output logic       uart_tx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_ferr,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy
);

  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

  logic        rx_s1_q, rx_s2_q, rx_s3_q;
  uart_state_e rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_sh_q, rx_sh_d;
  logic        rx_valid_q, rx_valid_d;
  logic        rx_ferr_q, rx_ferr_d;

  uart_state_e tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_sh_q, tx_sh_d;
  logic        tx_q, tx_d;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_valid_d = 1'b0;
    rx_ferr_d  = 1'b0;
    unique case (rx_state_q)
      U_IDLE: begin
        if (rx_s3_q && !rx_s2_q) begin
          rx_state_d = U_START;
          rx_cnt_d   = '0;
        end
      end
      U_START: begin
        // A line that is high again at mid start bit was only a glitch
        if (rx_cnt_q == HALF_LAST) begin
          rx_state_d = rx_s2_q ? U_IDLE : U_DATA;
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      U_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d = '0;
          rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
          rx_bit_d = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = U_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      U_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_state_d = U_IDLE;
          rx_valid_d = rx_s2_q;
          rx_ferr_d  = !rx_s2_q;
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      default: rx_state_d = U_IDLE;
    endcase
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_d       = tx_q;
    unique case (tx_state_q)
      U_IDLE: begin
        tx_d = 1'b1;
        if (tx_start) begin
          tx_sh_d    = tx_data;
          tx_state_d = U_START;
          tx_cnt_d   = '0;
          tx_d       = 1'b0;
        end
      end
      U_START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = U_DATA;
          tx_d       = tx_sh_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      U_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = U_STOP;
            tx_d       = 1'b1;
          end else begin
            tx_bit_d = tx_bit_q + 3'd1;
            tx_sh_d  = {1'b0, tx_sh_q[7:1]};
            tx_d     = tx_sh_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      U_STOP: begin
        if (tx_cnt_q == BIT_LAST) tx_state_d = U_IDLE;
        else tx_cnt_d = tx_cnt_q + 16'd1;
      end
      default: tx_state_d = U_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_s3_q    <= 1'b1;
      rx_state_q <= U_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
      tx_state_q <= U_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      tx_q       <= 1'b1;
    end else begin
      rx_s1_q    <= uart_rx;
      rx_s2_q    <= rx_s1_q;
      rx_s3_q    <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_valid_q <= rx_valid_d;
      rx_ferr_q  <= rx_ferr_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      tx_q       <= tx_d;
    end
  end

  assign rx_data  = rx_sh_q;
  assign rx_valid = rx_valid_q;
  assign rx_ferr  = rx_ferr_q;
  assign uart_tx  = tx_q;
  assign tx_busy  = (tx_state_q != U_IDLE);

endmodule

// File: rtl/uart_apb_bridge.sv
// rtl/uart_apb_bridge.sv - UART command frames to single APB transfers, with UART responses
module uart_apb_bridge
  import uart_apb_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic [19:0] paddr,
  output logic        pwrite,
  output logic        psel,
  output logic        penable,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata,
  output logic        busy
);

  logic [7:0] rx_data;
  logic       rx_valid, rx_ferr;
  logic       tx_start, tx_busy;

  cmd_state_e              state_q, state_d;
  logic [1:0]              cnt_q, cnt_d;
  logic [19:0]             addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic                    is_wr_q, is_wr_d;
  logic [19:0]             paddr_q, paddr_d;
  logic [31:0]             pwdata_q, pwdata_d;
  logic [31:0]             resp_q, resp_d;
  logic [2:0]              resp_cnt_q, resp_cnt_d;
  logic [TIMEOUT_BITS-1:0] tmo_q, tmo_d;
  logic                    busy_q, busy_d;

  uart_8n1 #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
    .clk      (clk),
    .resetn   (resetn),
    .uart_rx  (uart_rx),
    .uart_tx  (uart_tx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ferr  (rx_ferr),
    .tx_data  (resp_q[31:24]),
    .tx_start (tx_start),
    .tx_busy  (tx_busy)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    is_wr_d    = is_wr_q;
    paddr_d    = paddr_q;
    pwdata_d   = pwdata_q;
    resp_d     = resp_q;
    resp_cnt_d = resp_cnt_q;
    tmo_d      = tmo_q;
    tx_start   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        tmo_d = '0;
        cnt_d = '0;
        if (rx_valid) begin
          if (rx_data == CMD_WR || rx_data == CMD_RD) begin
            state_d = ST_ADDR;
            is_wr_d = (rx_data == CMD_WR);
          end else begin
            state_d    = ST_RESP;
            resp_d     = {RSP_ERR, 24'h0};
            resp_cnt_d = 3'd1;
          end
        end
      end
      ST_ADDR, ST_DATA: begin
        if (rx_ferr || tmo_q == '1) begin
          state_d = ST_ABORT;
        end else if (rx_valid) begin
          tmo_d = '0;
          cnt_d = cnt_q + 2'd1;
          if (state_q == ST_ADDR) begin
            // Shifting through 20 bits drops A2[7:4] naturally
            addr_d = {addr_q[11:0], rx_data};
            if (cnt_q == 2'd2) begin
              cnt_d   = '0;
              state_d = is_wr_q ? ST_DATA : ST_SETUP;
            end
          end else begin
            wdata_d = {wdata_q[23:0], rx_data};
            if (cnt_q == 2'd3) state_d = ST_SETUP;
          end
        end else begin
          tmo_d = tmo_q + TIMEOUT_BITS'(1);
        end
      end
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: begin
        state_d = ST_RESP;
        if (is_wr_q) begin
          resp_d     = {RSP_ACK, 24'h0};
          resp_cnt_d = 3'd1;
        end else begin
          resp_d     = prdata;
          resp_cnt_d = 3'd4;
        end
      end
      ST_RESP: begin
        if (resp_cnt_q != 3'd0) begin
          if (!tx_busy) begin
            tx_start   = 1'b1;
            resp_d     = {resp_q[23:0], 8'h00};
            resp_cnt_d = resp_cnt_q - 3'd1;
          end
        end else if (!tx_busy) begin
          state_d = ST_IDLE;
        end
      end
      ST_ABORT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    // Bus address/data only move when a new transfer starts
    if (state_d == ST_SETUP && state_q != ST_SETUP) begin
      paddr_d  = addr_d;
      pwdata_d = wdata_d;
    end
    busy_d = !(state_d == ST_IDLE || state_d == ST_ABORT);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      is_wr_q    <= 1'b0;
      paddr_q    <= '0;
      pwdata_q   <= '0;
      resp_q     <= '0;
      resp_cnt_q <= '0;
      tmo_q      <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      is_wr_q    <= is_wr_d;
      paddr_q    <= paddr_d;
      pwdata_q   <= pwdata_d;
      resp_q     <= resp_d;
      resp_cnt_q <= resp_cnt_d;
      tmo_q      <= tmo_d;
      busy_q     <= busy_d;
    end
  end

  assign psel    = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign penable = (state_q == ST_ACCESS);
  assign pwrite  = psel && is_wr_q;
  assign paddr   = paddr_q;
  assign pwdata  = pwdata_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_uart_apb_bridge.sv
// tb/tb_uart_apb_bridge.sv - self-checking bench for uart_apb_bridge against a frame-level model
module tb_uart_apb_bridge;

  localparam int CPB = 16;
  localparam int TOB = 8;

  typedef struct packed {
    logic [19:0] addr;
    logic [31:0] wdata;
    logic        wr;
  } apb_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        uart_rx = 1'b1;
  logic        uart_tx;
  logic [19:0] paddr;
  logic        pwrite, psel, penable, busy;
  logic [31:0] pwdata, prdata;

  logic [31:0] slave_mem [256];
  logic [31:0] ref_mem [256];
  apb_t        apb_q[$];
  logic [7:0]  rsp_q[$];
  apb_t        cur;
  bit          in_xfer = 1'b0;
  int          link_err = 0;
  int          checks = 0;
  int          errors = 0;
  int          wait_n;

  always #5 clk = ~clk;

  assign prdata = slave_mem[paddr[7:0]];

  uart_apb_bridge #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TOB)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .uart_rx (uart_rx),
    .uart_tx (uart_tx),
    .paddr   (paddr),
    .pwrite  (pwrite),
    .psel    (psel),
    .penable (penable),
    .pwdata  (pwdata),
    .prdata  (prdata),
    .busy    (busy)
  );

  function automatic logic [31:0] init_val(input int i);
    return (i == 0) ? 32'h0000_0001 : {8'hC3, 8'(i), 16'(i * 37)};
  endfunction

  // APB slave/monitor: logs transfers and counts protocol violations
  initial forever begin
    @(negedge clk);
    if (!resetn) begin
      in_xfer = 1'b0;
    end else if (psel && !penable) begin
      if (in_xfer) link_err++;
      in_xfer   = 1'b1;
      cur.addr  = paddr;
      cur.wdata = pwdata;
      cur.wr    = pwrite;
    end else if (psel && penable) begin
      if (!in_xfer || paddr !== cur.addr || pwdata !== cur.wdata || pwrite !== cur.wr) link_err++;
      in_xfer = 1'b0;
      apb_q.push_back(cur);
      if (cur.wr) slave_mem[cur.addr[7:0]] = cur.wdata;
    end else begin
      if (in_xfer || penable || pwrite) link_err++;
      in_xfer = 1'b0;
    end
  end

  // UART receiver on the DUT's TX line
  initial forever begin
    logic [7:0] v;
    @(negedge uart_tx);
    if (resetn) begin
      repeat (CPB / 2) @(posedge clk);
      #1;
      if (uart_tx !== 1'b0) link_err++;
      for (int b = 0; b < 8; b++) begin
        repeat (CPB) @(posedge clk);
        #1;
        v[b] = uart_tx;
      end
      repeat (CPB) @(posedge clk);
      #1;
      if (uart_tx !== 1'b1) link_err++;
      rsp_q.push_back(v);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(posedge clk);
    uart_rx = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(posedge clk);
    end
    uart_rx = stop;
    repeat (CPB) @(posedge clk);
    uart_rx = 1'b1;
  endtask

  task automatic wait_done(input int nbytes);
    int n = 0;
    while ((rsp_q.size() < nbytes || busy) && n < 6000) begin
      @(negedge clk);
      n++;
    end
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic xact(input bit wr, input logic [7:0] a2, input logic [7:0] a1,
                      input logic [7:0] a0, input logic [31:0] d, input string tag);
    logic [19:0] a;
    logic [31:0] v;
    logic [7:0]  exp[$];
    logic [7:0]  got;
    a = {a2[3:0], a1, a0};
    apb_q.delete();
    rsp_q.delete();
    send_byte(wr ? 8'h57 : 8'h52, 1'b1);
    send_byte(a2, 1'b1);
    send_byte(a1, 1'b1);
    send_byte(a0, 1'b1);
    if (wr) begin
      for (int i = 3; i >= 0; i--) send_byte(d[i*8 +: 8], 1'b1);
      ref_mem[a[7:0]] = d;
      exp.push_back(8'h4B);
    end else begin
      v = ref_mem[a[7:0]];
      for (int i = 3; i >= 0; i--) exp.push_back(v[i*8 +: 8]);
    end
    wait_done(exp.size());
    check({tag, "_nrsp"}, 32'(rsp_q.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      got = (i < rsp_q.size()) ? rsp_q[i] : 8'hxx;
      check({tag, "_rsp"}, 32'(got), 32'(exp[i]));
    end
    check({tag, "_napb"}, 32'(apb_q.size()), 32'd1);
    if (apb_q.size() > 0) begin
      check({tag, "_paddr"}, 32'(apb_q[0].addr), 32'(a));
      check({tag, "_pwrite"}, 32'(apb_q[0].wr), 32'(wr));
      if (wr) check({tag, "_pwdata"}, apb_q[0].wdata, d);
    end
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      slave_mem[i] = init_val(i);
      ref_mem[i]   = init_val(i);
    end
    repeat (5) @(negedge clk);
    check("rst_uart_tx", 32'(uart_tx), 32'd1);
    check("rst_psel", 32'(psel), 32'd0);
    check("rst_penable", 32'(penable), 32'd0);
    check("rst_pwrite", 32'(pwrite), 32'd0);
    check("rst_paddr", 32'(paddr), 32'd0);
    check("rst_pwdata", pwdata, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    resetn = 1'b1;
    repeat (5) @(negedge clk);

    xact(1'b1, 8'h00, 8'h01, 8'h24, 32'hDEADBEEF, "wr_dir");
    check("hold_paddr", 32'(paddr), 32'h00124);
    check("hold_pwdata", pwdata, 32'hDEADBEEF);
    check("idle_pwrite", 32'(pwrite), 32'd0);
    xact(1'b0, 8'h10, 8'h00, 8'h00, 32'h0, "rd_dir");

    apb_q.delete();
    rsp_q.delete();
    send_byte(8'hA5, 1'b1);
    wait_done(1);
    check("unk_nrsp", 32'(rsp_q.size()), 32'd1);
    if (rsp_q.size() > 0) check("unk_rsp", 32'(rsp_q[0]), 32'h3F);
    check("unk_napb", 32'(apb_q.size()), 32'd0);

    for (int k = 0; k < 6; k++) begin
      xact(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 8'($urandom),
           $urandom, "rnd");
    end

    apb_q.delete();
    rsp_q.delete();
    send_byte(8'h57, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h10, 1'b1);
    send_byte(8'hAA, 1'b1);
    @(negedge clk);
    check("tmo_busy_hi", 32'(busy), 32'd1);
    repeat (400) @(negedge clk);
    check("tmo_busy_lo", 32'(busy), 32'd0);
    check("tmo_napb", 32'(apb_q.size()), 32'd0);
    check("tmo_nrsp", 32'(rsp_q.size()), 32'd0);
    xact(1'b0, 8'h00, 8'h00, 8'h24, 32'h0, "rd_after_tmo");

    apb_q.delete();
    rsp_q.delete();
    send_byte(8'h52, 1'b1);
    send_byte(8'h10, 1'b0);
    repeat (100) @(negedge clk);
    check("ferr_busy", 32'(busy), 32'd0);
    check("ferr_napb", 32'(apb_q.size()), 32'd0);
    check("ferr_nrsp", 32'(rsp_q.size()), 32'd0);

    @(posedge clk);
    uart_rx = 1'b0;
    repeat (CPB / 2 - 2) @(posedge clk);
    uart_rx = 1'b1;
    repeat (300) @(negedge clk);
    check("glitch_nrsp", 32'(rsp_q.size()), 32'd0);
    check("glitch_busy", 32'(busy), 32'd0);
    xact(1'b0, 8'h00, 8'h01, 8'h24, 32'h0, "rd_after_glitch");

    apb_q.delete();
    rsp_q.delete();
    send_byte(8'h57, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    fork
      send_byte(8'h44, 1'b1);
      begin
        wait_n = 0;
        do begin
          @(negedge clk);
          wait_n++;
        end while (!(psel && penable) && wait_n < 3000);
        check("rstx_access_seen", 32'(psel && penable && pwrite), 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        check("rstx_psel", 32'(psel), 32'd0);
        check("rstx_penable", 32'(penable), 32'd0);
        check("rstx_pwrite", 32'(pwrite), 32'd0);
        check("rstx_uart_tx", 32'(uart_tx), 32'd1);
        check("rstx_busy", 32'(busy), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        apb_q.delete();
        rsp_q.delete();
      end
    join
    repeat (1000) @(negedge clk);
    check("rstx_nrsp", 32'(rsp_q.size()), 32'd0);
    check("rstx_napb", 32'(apb_q.size()), 32'd0);
    check("rstx_busy_after", 32'(busy), 32'd0);

    check("link_protocol", 32'(link_err), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_apb_bridge.md
Name: uart_apb_bridge

Overview:
- Host-side debug/loader master that sits directly upstream of the flunkyfive APB slave port.
- Receives framed read/write commands over a 115200-class 8N1 UART and issues single APB transfers (20-bit address, 32-bit data).
- Returns the read data or a write acknowledge over UART TX.
- Used to load flunky program RAM (0x0xxxx), poke the control CSR (0x1xxxx), and read both back.

Parameters:
- CLKS_PER_BIT, 104, clk cycles per UART bit; legal range 8..65535.
- TIMEOUT_BITS, 20, width of the inter-byte timeout counter; an incomplete frame aborts after 2^TIMEOUT_BITS idle cycles.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- uart_rx  in  1  serial input, asynchronous to clk
- uart_tx  out  1  serial output, idle high
- paddr  out  20  APB address
- pwrite  out  1  APB write strobe
- psel  out  1  APB select
- penable  out  1  APB enable
- pwdata  out  32  APB write data
- prdata  in  32  APB read data
- busy  out  1  high from first frame byte until last response byte has left TX

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While resetn is low:
  - uart_tx=1; psel=penable=pwrite=0; paddr=0; pwdata=0; busy=0.
  - Both UART FSMs are idle.
  - A reset mid-frame or mid-transfer discards everything; no partial APB cycle is issued after release.
- RX:
  - uart_rx passes through a 2-flop synchronizer.
  - A falling edge in IDLE starts a bit counter. The line is re-checked at half a bit; if it is high, the edge is a glitch and RX returns to idle.
  - Data bits are sampled at bit centres, LSB first.
  - Stop bit = 0 is a framing error: the byte is dropped and any frame in progress is aborted.
  - A good byte produces a 1-cycle rx_valid.
- TX:
  - 8N1, LSB first.
  - Accepts a byte when idle. The next byte can start on the cycle after the stop bit ends (no extra idle bit).
- Frames (multi-byte fields are big-endian):
  - Write: 0x57, A2, A1, A0, D3, D2, D1, D0. Address = {A2[3:0], A1, A0}; A2[7:4] ignored. Response 0x4B.
  - Read: 0x52, A2, A1, A0. Response D3, D2, D1, D0 of the captured prdata.
  - Any other command byte in IDLE: respond 0x3F; no APB activity.
- Command FSM:
  - States: IDLE, ADDR (count 3), DATA (count 4, write only), SETUP, ACCESS, RESP, ABORT.
  - IDLE -> ADDR on 0x57 or 0x52.
  - ADDR -> DATA (write) or SETUP (read) after the third address byte.
  - DATA -> SETUP after the fourth data byte.
  - SETUP: one cycle; psel=1, penable=0; paddr, pwrite and pwdata stable.
  - ACCESS: one cycle; psel=1, penable=1. There is no pready, so every transfer is exactly 2 cycles. prdata is captured on the clk edge that ends ACCESS.
  - After ACCESS: psel=0 and penable=0 in the same cycle RESP is entered. paddr and pwdata hold their values until the next SETUP. pwrite returns to 0.
  - RESP: queues the 1 or 4 response bytes to TX, then returns to IDLE.
  - RX bytes arriving during SETUP, ACCESS or RESP are discarded.
- Timeout: in ADDR or DATA, the counter clears on each rx_valid. At terminal count, go to IDLE with no response and no APB cycle.
- Framing error in ADDR or DATA: same handling as timeout.
- busy: asserted on the cycle after a valid command byte is accepted. Deasserted when RESP completes and the TX stop bit has finished. The 0x3F response for an unknown command also asserts busy while it is sent.

Decomposition:
- Package uart_apb_pkg holds:
  - command/response constants: CMD_WR=8'h57, CMD_RD=8'h52, RSP_ACK=8'h4B, RSP_ERR=8'h3F;
  - the FSM state encoding.
- Sub-module uart_8n1 (parameter CLKS_PER_BIT) contains the synchronizer, RX and TX.
  - RX side: rx_data[7:0], rx_valid, rx_ferr.
  - TX side: tx_data, tx_start, tx_busy.
- The top level contains only the command FSM, byte assembly, timeout and APB drive.

Test Plan:
- Write 0x57,0x00,0x01,0x24,0xDE,0xAD,0xBE,0xEF:
  - one APB cycle with paddr=0x00124, pwdata=0xDEADBEEF, pwrite=1, setup then access exactly 1 cycle each;
  - TX returns 0x4B.
- Read 0x52,0x10,0x00,0x00 with the slave driving prdata=0x00000001:
  - APB read at paddr=0x10000, pwrite=0;
  - TX returns 0x00,0x00,0x00,0x01.
- Unknown command byte 0xA5: TX returns 0x3F; psel stays 0 throughout.
- Write frame stalled after 5 bytes for longer than 2^TIMEOUT_BITS cycles (use TIMEOUT_BITS=8):
  - no APB cycle, no response, busy falls;
  - a subsequent full read frame works normally.
- Framing error (stop bit 0) injected on an address byte:
  - frame aborted, no APB cycle;
  - a 1/2-bit glitch on an idle line produces no byte.
- resetn pulsed low during ACCESS: psel, penable and pwrite are 0 immediately (asynchronously); uart_tx=1; no response is sent after release.
